// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared constants and FSM state type for the random-number service
//
// Contents:
//   LFSR_TAPS    : Galois feedback mask for the 16-bit LFSR
//   DEFAULT_SEED : LFSR reset value used when no seed is given
//   rng_state_t  : arbiter FSM states (IDLE, SCALE, RESP)

package rng_pkg;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCALE = 2'd1,
      RESP  = 2'd2
   } rng_state_t;

endpackage

// File: rtl/rng_lfsr.sv
// rtl/rng_lfsr.sv - free-running Galois LFSR noise source
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; loads SEED (or 1 when SEED is 0)
//   state : current LFSR value, advances every cycle

module rng_lfsr
   import rng_pkg::*;
#(
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [LFSR_W-1:0] state
);

   // An all-zero state would lock the LFSR, so a zero seed becomes 1.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(LFSR_TAPS);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEED_EFF;
      end else begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin shared LFSR with per-requester range scaling and cooldown
//
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high
//   req        : level request, one bit per requester
//   limit_flat : requester k limit at [k*OUT_W +: OUT_W]; result lies in [0, limit)
//   grant      : one-hot winner, only while valid is high
//   valid      : single-cycle response pulse
//   rnd_out    : scaled random value, zero whenever valid is low

module rng_arbiter
   import rng_pkg::*;
#(
   parameter int                NUM_REQ  = 4,
   parameter int                LFSR_W   = 16,
   parameter int                OUT_W    = 9,
   parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(DEFAULT_SEED),
   parameter int                COOLDOWN = 15000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*OUT_W-1:0] limit_flat,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     valid,
   output logic [OUT_W-1:0]         rnd_out
);

   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PROD_W = LFSR_W + OUT_W;
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

   rng_state_t          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    win_q;
   logic [LFSR_W-1:0]   sample_q;
   logic [OUT_W-1:0]    lim_q;
   logic [OUT_W-1:0]    result_q;
   logic [CD_W-1:0]     cd_q [NUM_REQ];
   logic [LFSR_W-1:0]   lfsr_val;
   logic [NUM_REQ-1:0]  eligible;
   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [OUT_W-1:0]    lim_sel;

   rng_lfsr #(
      .LFSR_W (LFSR_W),
      .SEED   (SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .state (lfsr_val)
   );

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible[k] = req[k] & (cd_q[k] == '0);
      end
   end

   // Search starts at ptr and wraps, so the requester after the last winner
   // always has first claim.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   assign lim_sel = limit_flat[int'(pick)*OUT_W +: OUT_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      valid   = 1'b0;
      grant   = '0;
      rnd_out = '0;
      case (state_q)
         IDLE:    if (found) state_d = SCALE;
         SCALE:   state_d = RESP;
         RESP: begin
            state_d = IDLE;
            valid   = 1'b1;
            grant   = NUM_REQ'(1) << win_q;
            rnd_out = result_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Winner, sample and limit are frozen at the IDLE latch so later limit
   // changes or a dropped req cannot disturb the in-flight response.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q    <= '0;
         win_q    <= '0;
         sample_q <= '0;
         lim_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  win_q    <= pick;
                  sample_q <= lfsr_val;
                  lim_q    <= lim_sel;
               end
            end
            SCALE: begin
               // Upper OUT_W bits of sample*limit map the sample onto [0, limit).
               result_q <= OUT_W'((PROD_W'(sample_q) * PROD_W'(lim_q)) >> LFSR_W);
            end
            RESP: begin
               ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cd
      always_ff @(posedge clk) begin
         if (reset) begin
            cd_q[k] <= '0;
         end else if (state_q == RESP && win_q == IDX_W'(k)) begin
            cd_q[k] <= CD_LOAD;
         end else if (cd_q[k] != '0) begin
            cd_q[k] <= cd_q[k] - CD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - randomized self-checking bench for rng_arbiter

module tb_rng_arbiter;
   import rng_pkg::*;

   localparam int N  = 4;
   localparam int OW = 9;
   localparam int C  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic [N*OW-1:0]   limit_flat;
   logic [N-1:0]      grant, grant0;
   logic              valid, valid0;
   logic [OW-1:0]     rnd_out, rnd_out0;

   always #5 clk = ~clk;

   rng_arbiter #(.NUM_REQ(N), .LFSR_W(16), .OUT_W(OW), .SEED(16'hACE1), .COOLDOWN(C)) dut (
      .clk(clk), .reset(reset), .req(req), .limit_flat(limit_flat),
      .grant(grant), .valid(valid), .rnd_out(rnd_out));

   rng_arbiter #(.NUM_REQ(N), .LFSR_W(16), .OUT_W(OW), .SEED(16'h0000), .COOLDOWN(0)) dut0 (
      .clk(clk), .reset(reset), .req(req), .limit_flat(limit_flat),
      .grant(grant0), .valid(valid0), .rnd_out(rnd_out0));

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: response scheduling from the rules (latch in IDLE, respond
   // two cycles later, idle again one cycle after that, cooldown ready time).
   int          cyc = 0;
   logic [15:0] m_lfsr;
   int          m_ptr, m_idle_at, m_pend_at, m_pend_w;
   bit          m_pend;
   logic [OW-1:0] m_pend_val, m_pend_lim;
   int          m_ready_at [N];
   int          n_resp = 0;
   bit          saw_valid;
   int          valid_cyc;
   logic [OW-1:0] last_rnd;
   logic [N-1:0]  last_grant;

   bit rr_on = 0;
   int rr_exp, rr_last, rr_n;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset();
      m_lfsr    = 16'hACE1;
      m_ptr     = 0;
      m_idle_at = cyc + 1;
      m_pend    = 0;
      for (int k = 0; k < N; k++) m_ready_at[k] = 0;
   endtask

   task automatic step();
      bit exp_v;
      logic [31:0] p;
      int k;
      @(negedge clk);
      exp_v = m_pend && (cyc == m_pend_at);
      check_eq("valid", 32'(valid), 32'(exp_v));
      check_eq("grant", 32'(grant), exp_v ? (32'd1 << m_pend_w) : 32'd0);
      check_eq("rnd_out", 32'(rnd_out), exp_v ? 32'(m_pend_val) : 32'd0);
      check_eq("lfsr", 32'(dut.u_lfsr.state), 32'(m_lfsr));
      saw_valid = valid;
      if (valid) begin
         valid_cyc  = cyc;
         last_rnd   = rnd_out;
         last_grant = grant;
      end
      if (exp_v) begin
         n_resp++;
         if (m_pend_lim != 0) check_eq("range", 32'(rnd_out < m_pend_lim), 32'd1);
      end
      if (rr_on && valid0) begin
         check_eq("rr_grant", 32'(grant0), 32'd1 << rr_exp);
         if (rr_last >= 0) check_eq("rr_gap", cyc - rr_last, 32'd3);
         rr_last = cyc;
         rr_exp  = (rr_exp + 1) % N;
         rr_n++;
      end
      if (reset) begin
         model_reset();
      end else begin
         if (exp_v) begin
            m_ptr                 = (m_pend_w + 1) % N;
            m_ready_at[m_pend_w]  = cyc + 1 + C;
            m_pend                = 0;
         end
         if (!m_pend && cyc >= m_idle_at) begin
            for (int i = 0; i < N; i++) begin
               k = (m_ptr + i) % N;
               if (!m_pend && req[k] && cyc >= m_ready_at[k]) begin
                  m_pend     = 1;
                  m_pend_w   = k;
                  m_pend_at  = cyc + 2;
                  m_idle_at  = cyc + 3;
                  m_pend_lim = limit_flat[k*OW +: OW];
                  p          = 32'(m_lfsr) * 32'(m_pend_lim);
                  m_pend_val = p[24:16];
               end
            end
         end
         m_lfsr = lfsr_next(m_lfsr);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic single_req(input logic [OW-1:0] lim);
      int n;
      limit_flat = {$urandom, $urandom};
      limit_flat[0 +: OW] = lim;
      req = 4'b0001;
      n = 0;
      do begin
         step();
         n++;
      end while (!saw_valid && n < 20);
      req = '0;
      check_eq("latency", n - 1, 32'd2);
      check_eq("single_grant", 32'(last_grant), 32'd1);
      if (lim <= 1) check_eq("rnd_zero", 32'(last_rnd), 32'd0);
      else          check_eq("rnd_le_lim", 32'(last_rnd <= lim - 1), 32'd1);
      idle(8);
   endtask

   initial begin
      int prev, target, guard;
      reset = 1'b1;
      req = '0;
      limit_flat = '0;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) step();
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_rnd", 32'(rnd_out), 32'd0);

      // LFSR start-up sequence
      reset = 1'b0;
      check_eq("lfsr_seed", 32'(dut.u_lfsr.state), 32'h0000ACE1);
      check_eq("lfsr_seed0", 32'(dut0.u_lfsr.state), 32'h00000001);
      step();
      check_eq("lfsr_second", 32'(dut.u_lfsr.state), 32'h0000E270);
      idle(4);

      // Single requests, including degenerate limits
      single_req(9'd100);
      single_req(9'd0);
      single_req(9'd1);
      single_req(9'd511);

      // Cooldown spacing with a held request
      req = 4'b0001;
      prev = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (saw_valid) begin
            if (prev >= 0) check_eq("cd_gap", valid_cyc - prev, C + 3);
            prev = valid_cyc;
         end
      end
      idle(10);

      // Round robin on the zero-cooldown instance, fresh from reset
      reset = 1'b1;
      step();
      step();
      reset  = 1'b0;
      req    = 4'b1111;
      rr_on  = 1;
      rr_exp = 0;
      rr_last = -1;
      rr_n   = 0;
      for (int i = 0; i < 40; i++) step();
      rr_on = 0;
      check_eq("rr_count", rr_n, 32'd13);
      idle(10);

      // Random sweep: random req patterns, limits re-randomized each cycle
      target = n_resp + 1000;
      guard = 0;
      while (n_resp < target && guard < 20000) begin
         req = 4'($urandom);
         for (int k = 0; k < N; k++) limit_flat[k*OW +: OW] = OW'($urandom_range(1, 511));
         step();
         guard++;
      end
      check_eq("sweep_done", 32'(n_resp >= target), 32'd1);
      idle(12);

      // Reset while in SCALE kills the response
      req = 4'b0010;
      step();
      check_eq("in_scale", 32'(dut.state_q), 32'(SCALE));
      reset = 1'b1;
      req   = 4'b1010;
      step();
      check_eq("rs_valid", 32'(valid), 32'd0);
      check_eq("rs_grant", 32'(grant), 32'd0);
      check_eq("rs_rnd", 32'(rnd_out), 32'd0);
      reset = 1'b0;
      guard = 0;
      do begin
         step();
         guard++;
      end while (!saw_valid && guard < 10);
      check_eq("rs_first_grant", 32'(last_grant), 32'b0010);
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
